// File: rtl/truth_table_sweeper.sv
// Walks a 4-input combinational stage through all 16 input vectors, captures
// its two responses per vector and scores them against expected truth tables.
module truth_table_sweeper #(
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [15:0] EXP_F1        = 16'hFF5E,
  parameter logic [15:0] EXP_F2        = 16'h5505
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        f1,
  input  logic        f2,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  err_cnt,
  output logic [3:0]  first_err_idx,
  output logic [15:0] f1_table,
  output logic [15:0] f2_table,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Last settle count before sampling; unused when SETTLE_CYCLES is 0.
  localparam logic [3:0] SETTLE_LAST =
    (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);
  localparam state_t AFTER_VECTOR = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

  state_t      state_q, state_d;
  logic [3:0]  vec_q, vec_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [4:0]  err_cnt_q, err_cnt_d;
  logic [3:0]  first_q, first_d;
  logic [15:0] f1_tab_q, f1_tab_d;
  logic [15:0] f2_tab_q, f2_tab_d;
  logic        mismatch;

  assign mismatch = (f1 != EXP_F1[vec_q]) || (f2 != EXP_F2[vec_q]);

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    err_cnt_d = err_cnt_q;
    first_d   = first_q;
    f1_tab_d  = f1_tab_q;
    f2_tab_d  = f2_tab_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          vec_d     = 4'd0;
          cnt_d     = 4'd0;
          err_cnt_d = 5'd0;
          first_d   = 4'd0;
          pass_d    = 1'b0;
          f1_tab_d  = 16'd0;
          f2_tab_d  = 16'd0;
          busy_d    = 1'b1;
          state_d   = AFTER_VECTOR;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      SAMPLE: begin
        f1_tab_d[vec_q] = f1;
        f2_tab_d[vec_q] = f2;
        if (mismatch) begin
          err_cnt_d = err_cnt_q + 5'd1;
          if (err_cnt_q == 5'd0) begin
            first_d = vec_q;
          end
        end
        if (vec_q == 4'd15) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = !mismatch && (err_cnt_q == 5'd0);
        end else begin
          vec_d   = vec_q + 4'd1;
          cnt_d   = 4'd0;
          state_d = AFTER_VECTOR;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      vec_q     <= 4'd0;
      cnt_q     <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_cnt_q <= 5'd0;
      first_q   <= 4'd0;
      f1_tab_q  <= 16'd0;
      f2_tab_q  <= 16'd0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_cnt_q <= err_cnt_d;
      first_q   <= first_d;
      f1_tab_q  <= f1_tab_d;
      f2_tab_q  <= f2_tab_d;
    end
  end

  assign {a, b, c, d}  = vec_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_idx = first_q;
  assign f1_table      = f1_tab_q;
  assign f2_table      = f2_tab_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: a settle-2 instance driven from a table of
// fault scenarios plus hand sequences, and a settle-0 instance.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start0 = 1'b0;
  int   mode = 0;

  logic        a, b, c, d, busy, done, pass, f1, f2;
  logic [4:0]  err_cnt;
  logic [3:0]  first_err_idx;
  logic [15:0] f1_table, f2_table;
  logic [1:0]  dbg_state;

  logic        a0, b0, c0, d0, busy0, done0, pass0, f1_0, f2_0;
  logic [4:0]  err_cnt0;
  logic [3:0]  first_err_idx0;
  logic [15:0] f1_table0, f2_table0;
  logic [1:0]  dbg_state0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          mode;
    logic [4:0]  err;
    logic [3:0]  first;
    logic        pass;
    logic [15:0] f1t;
    logic [15:0] f2t;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  // Stage model: 0 good, 1 f1 stuck-0, 2 f2 inverted, 3 f1 inverted,
  // 4 f2 stuck-1, 5 f1 wrong at vector 9, 6 both wrong at vectors 5 and 12.
  function automatic logic model_f1(input logic [3:0] v, input int m);
    logic g;
    g = v[3] | (~v[2] & v[1]) | ((~v[3] & v[2]) ^ v[0]);
    case (m)
      1: return 1'b0;
      3: return ~g;
      5: return (v == 4'd9) ? ~g : g;
      6: return (v == 4'd5 || v == 4'd12) ? ~g : g;
      default: return g;
    endcase
  endfunction

  function automatic logic model_f2(input logic [3:0] v, input int m);
    logic g;
    g = ~((~v[3] & v[2]) | v[0]);
    case (m)
      2: return ~g;
      4: return 1'b1;
      6: return (v == 4'd5 || v == 4'd12) ? ~g : g;
      default: return g;
    endcase
  endfunction

  assign f1   = model_f1({a, b, c, d}, mode);
  assign f2   = model_f2({a, b, c, d}, mode);
  assign f1_0 = model_f1({a0, b0, c0, d0}, mode);
  assign f2_0 = model_f2({a0, b0, c0, d0}, mode);

  truth_table_sweeper #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .f1(f1), .f2(f2),
    .a(a), .b(b), .c(c), .d(d), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .first_err_idx(first_err_idx),
    .f1_table(f1_table), .f2_table(f2_table), .dbg_state(dbg_state)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .f1(f1_0), .f2(f2_0),
    .a(a0), .b(b0), .c(c0), .d(d0), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(err_cnt0), .first_err_idx(first_err_idx0),
    .f1_table(f1_table0), .f2_table(f2_table0), .dbg_state(dbg_state0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_results(input vec_t v);
    check("pass", 32'(pass), 32'(v.pass));
    check("err_cnt", 32'(err_cnt), 32'(v.err));
    check("first_err_idx", 32'(first_err_idx), 32'(v.first));
    check("f1_table", 32'(f1_table), 32'(v.f1t));
    check("f2_table", 32'(f2_table), 32'(v.f2t));
  endtask

  // Called at #1 after an edge with the DUT idle. repulse > 0 re-pulses start
  // during that cycle of the sweep, which must be ignored.
  task automatic run_sweep(input vec_t v, input int repulse);
    int n;
    int ev;
    mode  = v.mode;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    n = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      n = k;
      start = (k == repulse);
      ev = (k / 3 > 15) ? 15 : k / 3;
      check("vector", 32'({a, b, c, d}), 32'(ev));
      if (done) break;
      check("busy_during", 32'(busy), 32'd1);
    end
    start = 1'b0;
    check("done_latency", 32'(n), 32'd48);
    check("busy_at_done", 32'(busy), 32'd0);
    check_results(v);
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_state", 32'(dbg_state), 32'd0);
    tick();
    check_results(v);
  endtask

  task automatic run_sweep0(input vec_t v);
    int n;
    mode   = v.mode;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    n = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      n = k;
      check("vector0", 32'({a0, b0, c0, d0}), 32'((k > 15) ? 15 : k));
      if (done0) break;
    end
    check("done0_latency", 32'(n), 32'd16);
    check("pass0", 32'(pass0), 32'(v.pass));
    check("err_cnt0", 32'(err_cnt0), 32'(v.err));
    check("first0", 32'(first_err_idx0), 32'(v.first));
    check("f1_table0", 32'(f1_table0), 32'(v.f1t));
    check("f2_table0", 32'(f2_table0), 32'(v.f2t));
    tick();
    tick();
  endtask

  initial begin
    int n;
    int first_done;
    vecs[0] = '{0, 5'd0,  4'd0, 1'b1, 16'hFF5E, 16'h5505};
    vecs[1] = '{1, 5'd13, 4'd1, 1'b0, 16'h0000, 16'h5505};
    vecs[2] = '{2, 5'd16, 4'd0, 1'b0, 16'hFF5E, 16'hAAFA};
    vecs[3] = '{3, 5'd16, 4'd0, 1'b0, 16'h00A1, 16'h5505};
    vecs[4] = '{4, 5'd10, 4'd1, 1'b0, 16'hFF5E, 16'hFFFF};
    vecs[5] = '{5, 5'd1,  4'd9, 1'b0, 16'hFD5E, 16'h5505};
    vecs[6] = '{6, 5'd2,  4'd5, 1'b0, 16'hEF7E, 16'h4525};

    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_vector", 32'({a, b, c, d}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check_results('{0, 5'd0, 4'd0, 1'b0, 16'h0, 16'h0});
    rst = 1'b0;
    tick();

    foreach (vecs[i]) run_sweep(vecs[i], 0);

    run_sweep(vecs[0], 20);

    // Reset at vector 7 of an f1-stuck sweep; start asserted alongside rst.
    mode  = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if ({a, b, c, d} == 4'd7) break;
      tick();
      n = k + 1;
    end
    check("reach_vector7", 32'({a, b, c, d}), 32'd7);
    check("partial_err_cnt", 32'(err_cnt), 32'd5);
    check("partial_first", 32'(first_err_idx), 32'd1);
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_vector", 32'({a, b, c, d}), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'd0);
    check_results('{0, 5'd0, 4'd0, 1'b0, 16'h0, 16'h0});
    tick();
    check("rst_beats_start", 32'(busy), 32'd0);
    run_sweep(vecs[0], 0);

    // start held high: relaunch on the first IDLE cycle after DONE.
    mode  = 0;
    start = 1'b1;
    tick();
    first_done = 0;
    n = 0;
    for (int k = 1; k <= 120; k++) begin
      tick();
      if (k == 49) check("held_idle_gap", 32'(busy), 32'd0);
      if (k == 50) check("held_relaunch", 32'(busy), 32'd1);
      if (done && first_done == 0) first_done = k;
      else if (done) begin
        n = k;
        break;
      end
    end
    start = 1'b0;
    check("held_first_done", 32'(first_done), 32'd48);
    check("held_second_done", 32'(n), 32'd98);
    check_results(vecs[0]);
    tick();
    tick();

    run_sweep0(vecs[0]);
    run_sweep0(vecs[2]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, hold cycles per vector before sampling (legal 0..15).
REQ-002 SHALL have parameter EXP_F1, default 16'hFF5E, expected f1 per vector; bit i = vector i.
REQ-003 SHALL have parameter EXP_F2, default 16'h5505, expected f2 per vector; bit i = vector i.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  begins a sweep when sampled high in IDLE.
REQ-007 f1  input  1  f1 response from the downstream combinational stage.
REQ-008 f2  input  1  f2 response from the downstream combinational stage.
REQ-009 a, b, c, d  output  1 each  stimulus to the combinational stage; {a,b,c,d} = current vector, a is the MSB.
REQ-010 busy  output  1  high while a sweep is in progress.
REQ-011 done  output  1  one-cycle pulse at the end of a sweep.
REQ-012 pass  output  1  high when the last completed sweep had zero mismatches.
REQ-013 err_cnt  output  5  number of mismatching vectors in the current or last sweep (0..16).
REQ-014 first_err_idx  output  4  index of the first mismatching vector; 0 if none.
REQ-015 f1_table, f2_table  output  16 each  captured responses; bit i = vector i.

Function
REQ-016 SHALL implement states IDLE, SETTLE, SAMPLE and DONE, with all outputs registered.
REQ-017 IDLE: start=1 at an edge SHALL set vector=0, settle count=0, err_cnt=0, first_err_idx=0, pass=0, both tables=0 and busy=1, then go to SETTLE (or to SAMPLE if SETTLE_CYCLES=0).
REQ-018 SETTLE SHALL hold the vector for exactly SETTLE_CYCLES cycles, then go to SAMPLE.
REQ-019 SAMPLE (one cycle) SHALL write f1 into f1_table[vector] and f2 into f2_table[vector].
REQ-020 SAMPLE SHALL count a mismatch when f1≠EXP_F1[vector] or f2≠EXP_F2[vector]; one increment per vector even if both differ.
REQ-021 On the first mismatch of a sweep (err_cnt was 0), first_err_idx SHALL latch the vector; it SHALL not change on later mismatches.
REQ-022 SAMPLE with vector<15 SHALL increment the vector and re-enter SETTLE (or SAMPLE if SETTLE_CYCLES=0).
REQ-023 SAMPLE with vector=15 SHALL go to DONE with no wrap; the vector stays 15.
REQ-024 DONE SHALL last one cycle with done=1, busy=0 and pass=(err_cnt==0), then return to IDLE.
REQ-025 Each vector SHALL take SETTLE_CYCLES+1 cycles.
REQ-026 done SHALL rise 16*(SETTLE_CYCLES+1) edges after the edge that accepted start.
REQ-027 start SHALL be ignored in SETTLE, SAMPLE and DONE; start held high SHALL launch a new sweep on the first IDLE cycle after DONE.
REQ-028 pass, err_cnt, first_err_idx and the tables SHALL hold their values in IDLE until the next accepted start or reset.
REQ-029 err_cnt SHALL saturate naturally at 16 (5 bits; no overflow possible).

Reset
REQ-030 rst=1 at an edge SHALL force state IDLE regardless of the current state, including mid-sweep.
REQ-031 rst=1 SHALL clear vector (a,b,c,d=0), busy, done, pass, err_cnt, first_err_idx, f1_table and f2_table to 0.
REQ-032 rst SHALL take priority over start in the same cycle.
REQ-033 No partial-sweep results SHALL survive reset.

Verification
REQ-034 Good DUT model (f1 = a | b'c | (a'b ^ d), f2 = ~(a'b | d)), SETTLE_CYCLES=2, start pulse -> done at edge +48; pass=1, err_cnt=0, f1_table=16'hFF5E, f2_table=16'h5505.
REQ-035 f1 stuck at 0, f2 correct -> err_cnt=13, first_err_idx=1, pass=0, f1_table=16'h0000.
REQ-036 Good DUT, reset asserted at vector 7 -> next cycle busy=0, all outputs 0; a fresh start then completes normally with pass=1.
REQ-037 start re-pulsed during busy -> no restart; done still at edge +48 of the original start.
REQ-038 SETTLE_CYCLES=0, good DUT -> vector advances every cycle; done at edge +16; pass=1.
REQ-039 f2 inverted (f1 correct) -> err_cnt=16, first_err_idx=0, pass=0, f2_table=16'hAAFA.
